// File: rtl/clk_div_ctrl_if.sv
// Wishbone slave bus bundle for the clock-divider ramp controller.
interface clk_div_ctrl_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [1:0]  wb_adr;
    logic [15:0] wb_i_dat;
    logic [15:0] wb_o_dat;
    logic        wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
        input  wb_o_dat, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_i_dat,
        output wb_o_dat, wb_ack
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Ramps the downstream clock divider one exponent step at a time toward a software target.
// Optional sticky write-lock on TARGET/INTERVAL is built when CLK_DIV_LOCK_EN is defined.
module clk_div_ctrl #(
    parameter int          DIV_LOG      = 4,
    parameter int          RST_DIV      = 6,
    parameter logic [15:0] DEF_INTERVAL = 16'd256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    clk_div_ctrl_if.slave      wb,
    output logic [DIV_LOG-1:0] o_div,
    output logic               o_div_we,
    output logic               o_busy
);

    localparam logic [DIV_LOG-1:0] RST_VAL = DIV_LOG'(RST_DIV);
    localparam logic [DIV_LOG-1:0] ONE     = {{(DIV_LOG-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               step_s;
    logic               dir_up_r;
    logic [DIV_LOG-1:0] cur_r;
    logic [DIV_LOG-1:0] tgt_r;
    logic [DIV_LOG-1:0] next_cur_s;
    logic [15:0]        interval_r;
    logic [15:0]        cnt_r;
    logic [DIV_LOG-1:0] div_r;
    logic               div_we_r;
    logic               ack_r;
    logic [15:0]        rdat_r;
    logic [15:0]        rd_s;
    logic               acc_s;
    logic               wr_s;
    logic               wr_ok_s;
    logic               busy_s;

    assign acc_s      = wb.wb_cyc & wb.wb_stb & ~ack_r;
    assign wr_s       = acc_s & wb.wb_we;
    assign busy_s     = (state_r != IDLE) | (cur_r != tgt_r);
    assign next_cur_s = dir_up_r ? (cur_r + ONE) : (cur_r - ONE);

    assign wb.wb_ack  = ack_r;
    assign wb.wb_o_dat = rdat_r;
    assign o_div      = div_r;
    assign o_div_we   = div_we_r;
    assign o_busy     = busy_s;

`ifdef CLK_DIV_LOCK_EN
    logic lock_r;

    assign wr_ok_s = wr_s & ~lock_r;

    // Sticky lock bit, cleared only by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_r <= 1'b0;
        end else if (wr_s && (wb.wb_adr == 2'd3) && wb.wb_i_dat[0]) begin
            lock_r <= 1'b1;
        end
    end
`else
    assign wr_ok_s = wr_s;
`endif

    // Ramp FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Ramp FSM next state; WAIT leaves once the count is at 1 or 0, so WAIT lasts max(interval,1) cycles
    always_comb begin
        state_s = state_r;
        step_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cur_r != tgt_r) begin
                    state_s = STEP;
                end else begin
                    state_s = IDLE;
                end
            end
            STEP: begin
                step_s  = 1'b1;
                state_s = WAIT;
            end
            WAIT: begin
                if (cnt_r <= 16'd1) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Ramp datapath; direction is frozen on leaving IDLE so a target written during STEP cannot flip it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur_r    <= RST_VAL;
            div_r    <= RST_VAL;
            div_we_r <= 1'b0;
            dir_up_r <= 1'b0;
            cnt_r    <= 16'd0;
        end else begin
            div_we_r <= step_s;
            if (state_r == IDLE) begin
                dir_up_r <= (tgt_r > cur_r);
            end
            if (step_s) begin
                cur_r <= next_cur_s;
                div_r <= next_cur_s;
                cnt_r <= interval_r;
            end else if ((state_r == WAIT) && (cnt_r != 16'd0)) begin
                cnt_r <= cnt_r - 16'd1;
            end
        end
    end

    // Register read multiplexer, zero-extended
    always_comb begin
        rd_s = 16'd0;
        case (wb.wb_adr)
            2'd0: rd_s[DIV_LOG-1:0] = tgt_r;
            2'd1: begin
                rd_s[DIV_LOG:1] = cur_r;
                rd_s[0]         = busy_s;
            end
            2'd2: rd_s = interval_r;
`ifdef CLK_DIV_LOCK_EN
            2'd3: rd_s[0] = lock_r;
`else
            2'd3: rd_s = 16'd0;
`endif
            default: rd_s = 16'd0;
        endcase
    end

    // Bus handshake and software-visible registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_r      <= 1'b0;
            rdat_r     <= 16'd0;
            tgt_r      <= RST_VAL;
            interval_r <= DEF_INTERVAL;
        end else begin
            ack_r <= acc_s;
            if (acc_s) begin
                rdat_r <= rd_s;
            end else begin
                rdat_r <= 16'd0;
            end
            if (wr_ok_s && (wb.wb_adr == 2'd0)) begin
                tgt_r <= wb.wb_i_dat[DIV_LOG-1:0];
            end
            if (wr_ok_s && (wb.wb_adr == 2'd2)) begin
                interval_r <= wb.wb_i_dat;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: register vectors, directed ramps, async reset and random ramps.
module tb_clk_div_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [3:0] o_div;
    logic       o_div_we;
    logic       o_busy;

    clk_div_ctrl_if bus ();

    clk_div_ctrl #(
        .DIV_LOG      (4),
        .RST_DIV      (6),
        .DEF_INTERVAL (16'd256)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .wb       (bus),
        .o_div    (o_div),
        .o_div_we (o_div_we),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc_cnt = 0;
    always @(posedge i_clk) cyc_cnt++;

    typedef struct { int cyc; int val; } pulse_t;
    pulse_t pq[$];

    // Strobe monitor, sampled mid-cycle
    always @(negedge i_clk) begin
        if (o_div_we === 1'b1) pq.push_back('{cyc_cnt, int'(o_div)});
    end

    typedef struct { bit we; bit [1:0] adr; bit [15:0] dat; } vec_t;

    int errors = 0;
    int checks = 0;
    int model_cur;
    int ack_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        model_cur = 6;
    endtask

    task automatic wb_access(input bit we, input logic [1:0] a, input logic [15:0] d, output logic [15:0] rd);
        bit got;
        got = 1'b0;
        rd  = 16'd0;
        @(negedge i_clk);
        bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1; bus.wb_we = we;
        bus.wb_adr = a;    bus.wb_i_dat = d;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            if (bus.wb_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        ack_cyc = cyc_cnt;
        rd = bus.wb_o_dat;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [15:0] d);
        logic [15:0] dummy;
        wb_access(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [15:0] rd);
        wb_access(1'b0, a, 16'd0, rd);
    endtask

    task automatic wait_idle(output int fall);
        fall = -1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge i_clk);
            if (o_busy === 1'b0) begin
                fall = cyc_cnt;
                break;
            end
        end
        if (fall < 0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Reference: a ramp from c to t strobes c+-1 .. t, one strobe per 2+max(iv,1) cycles
    task automatic run_ramp(input string tag, input int tgt, input int iv);
        int n, dir, sp, wt, fall, c0;
        logic [15:0] rd;
        pq.delete();
        wb_write(2'd2, 16'(iv));
        wb_write(2'd0, 16'(tgt));
        c0 = ack_cyc;
        wait_idle(fall);
        n   = (tgt > model_cur) ? (tgt - model_cur) : (model_cur - tgt);
        dir = (tgt > model_cur) ? 1 : -1;
        wt  = (iv == 0) ? 1 : iv;
        sp  = 2 + wt;
        check({tag, "_count"}, pq.size(), n);
        for (int i = 0; i < n && i < pq.size(); i++) begin
            check({tag, "_val"}, pq[i].val, model_cur + dir * (i + 1));
            if (i == 0) check({tag, "_latency"}, pq[0].cyc - c0, 2);
            else        check({tag, "_spacing"}, pq[i].cyc - pq[i-1].cyc, sp);
        end
        if (n > 0 && pq.size() == n) check({tag, "_busy_fall"}, fall, pq[n-1].cyc + wt);
        model_cur = tgt;
        wb_read(2'd1, rd);
        check({tag, "_status"}, rd, 32'(model_cur * 2));
        check({tag, "_o_div"}, o_div, model_cur);
    endtask

    vec_t vt[14];

    initial begin
        logic [15:0] rd;
        int          fall;
        int          exp_seq[6];
        bit          busy_seen;
        bit          ok;

        i_rst = 1'b1;
        bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
        bus.wb_adr = 2'd0; bus.wb_i_dat = 16'd0;
        model_cur = 6;

        vt = '{
            '{1'b0, 2'd0, 16'h0006},
            '{1'b0, 2'd1, 16'h000C},
            '{1'b0, 2'd2, 16'h0100},
            '{1'b0, 2'd3, 16'h0000},
            '{1'b1, 2'd2, 16'h1234},
            '{1'b0, 2'd2, 16'h1234},
            '{1'b1, 2'd1, 16'hFFFF},
            '{1'b0, 2'd1, 16'h000C},
            '{1'b1, 2'd0, 16'h0006},
            '{1'b0, 2'd1, 16'h000C},
            '{1'b1, 2'd0, 16'hFFF6},
            '{1'b0, 2'd0, 16'h0006},
            '{1'b1, 2'd3, 16'h0000},
            '{1'b0, 2'd3, 16'h0000}
        };

        do_reset();
        pq.delete();
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_busy !== 1'b0) busy_seen = 1'b1;
        end
        check("idle_o_div", o_div, 6);
        check("idle_strobes", pq.size(), 0);
        check("idle_busy", busy_seen, 0);

        for (int i = 0; i < 14; i++) begin
            if (vt[i].we) wb_write(vt[i].adr, vt[i].dat);
            else begin
                wb_read(vt[i].adr, rd);
                check($sformatf("vec%0d_adr%0d", i, vt[i].adr), rd, vt[i].dat);
            end
        end
        repeat (5) @(negedge i_clk);
        check("vec_no_strobe", pq.size(), 0);
        check("vec_busy", o_busy, 0);

        run_ramp("up9", 9, 4);

        do_reset();
        run_ramp("down2", 2, 0);

        // Reversal: target 12, then 4 written during the second WAIT
        do_reset();
        pq.delete();
        wb_write(2'd2, 16'd4);
        wb_write(2'd0, 16'd12);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (pq.size() >= 2) begin ok = 1'b1; break; end
        end
        check("rev_two_pulses", ok, 1);
        wb_write(2'd0, 16'd4);
        wait_idle(fall);
        exp_seq = '{7, 8, 7, 6, 5, 4};
        check("rev_count", pq.size(), 6);
        for (int i = 0; i < 6 && i < pq.size(); i++) check("rev_val", pq[i].val, exp_seq[i]);
        model_cur = 4;

        // Asynchronous reset in the middle of the strobe carrying 8
        do_reset();
        wb_write(2'd2, 16'd4);
        wb_write(2'd0, 16'd12);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (o_div_we === 1'b1 && o_div == 4'd8) begin ok = 1'b1; break; end
        end
        check("arst_reached8", ok, 1);
        #1 i_rst = 1'b1;
        #1;
        check("arst_o_div", o_div, 6);
        check("arst_o_div_we", o_div_we, 0);
        check("arst_busy", o_busy, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_cur = 6;
        wb_read(2'd0, rd);
        check("arst_target", rd, 6);

        for (int r = 0; r < 10; r++) begin
            run_ramp($sformatf("rnd%0d", r), int'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
        end

`ifdef CLK_DIV_LOCK_EN
        wb_write(2'd3, 16'd1);
        wb_read(2'd3, rd);
        check("lock_read", rd, 1);
        pq.delete();
        wb_write(2'd0, 16'((model_cur + 5) % 16));
        wb_read(2'd0, rd);
        check("lock_target", rd, model_cur);
        repeat (20) @(negedge i_clk);
        check("lock_no_strobe", pq.size(), 0);
`else
        wb_write(2'd3, 16'd1);
        wb_read(2'd3, rd);
        check("reg3_reads_zero", rd, 0);
        run_ramp("after_reg3", (model_cur + 3) % 16, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
